// File: rtl/ibex_bus_arbiter.sv
// Shares one Ibex-protocol slave port between NUM_MASTERS requesters, with lock-until-grant,
// an in-order ID FIFO for response routing and a sticky protocol-violation flag.
module ibex_bus_arbiter #(
    parameter int unsigned NUM_MASTERS     = 2,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter bit          RR_EN           = 1'b1,
    localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1),
    localparam int unsigned IdxW = $clog2(NUM_MASTERS),
    localparam int unsigned PtrW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NUM_MASTERS-1:0]    m_req_i,
    output logic [NUM_MASTERS-1:0]    m_gnt_o,
    output logic [NUM_MASTERS-1:0]    m_rvalid_o,
    input  logic [NUM_MASTERS-1:0]    m_we_i,
    input  logic [NUM_MASTERS*4-1:0]  m_be_i,
    input  logic [NUM_MASTERS*32-1:0] m_addr_i,
    input  logic [NUM_MASTERS*32-1:0] m_wdata_i,
    output logic [31:0]               m_rdata_o,
    output logic                      m_err_o,
    output logic                      s_req_o,
    output logic                      s_we_o,
    output logic [3:0]                s_be_o,
    output logic [31:0]               s_addr_o,
    output logic [31:0]               s_wdata_o,
    input  logic                      s_gnt_i,
    input  logic                      s_rvalid_i,
    input  logic                      s_err_i,
    input  logic [31:0]               s_rdata_i,
    output logic [CntW-1:0]           outstanding_o,
    output logic                      protocol_err_o
);

    logic [IdxW-1:0] sel;
    logic [IdxW-1:0] rr_q, rr_d;
    logic [IdxW-1:0] lock_idx_q, lock_idx_d;
    logic            lock_q, lock_d;
    logic            err_q, err_d;
    logic            full, push, pop;
    logic [IdxW-1:0] fifo_q [MAX_OUTSTANDING];
    logic [PtrW-1:0] wr_q, rd_q;
    logic [CntW-1:0] cnt_q, cnt_d;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full = (cnt_q == CntW'(MAX_OUTSTANDING));

    // Descending scan so the lowest offset from the start point wins.
    always_comb begin
        int unsigned j;
        j   = 0;
        sel = '0;
        if (lock_q) begin
            sel = lock_idx_q;
        end else if (RR_EN) begin
            for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
                j = int'(rr_q) + i;
                if (j >= NUM_MASTERS) j = j - NUM_MASTERS;
                if (m_req_i[IdxW'(j)]) sel = IdxW'(j);
            end
        end else begin
            for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
                if (m_req_i[i]) sel = IdxW'(i);
            end
        end
    end

    assign s_req_o   = m_req_i[sel] & ~full;
    assign s_we_o    = s_req_o & m_we_i[sel];
    assign s_be_o    = s_req_o ? m_be_i[4*sel +: 4] : '0;
    assign s_addr_o  = s_req_o ? m_addr_i[32*sel +: 32] : '0;
    assign s_wdata_o = s_req_o ? m_wdata_i[32*sel +: 32] : '0;

    assign push = s_req_o & s_gnt_i;
    assign pop  = s_rvalid_i & (cnt_q != '0);

    always_comb begin
        m_gnt_o      = '0;
        m_gnt_o[sel] = push;
        m_rvalid_o   = '0;
        if (pop) m_rvalid_o[fifo_q[rd_q]] = 1'b1;
    end

    assign m_rdata_o      = s_rdata_i;
    assign m_err_o        = s_err_i;
    assign outstanding_o  = cnt_q;
    assign protocol_err_o = err_q;

    always_comb begin
        rr_d       = rr_q;
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        err_d      = err_q;
        cnt_d      = cnt_q;
        if (RR_EN && push) rr_d = (sel == IdxW'(NUM_MASTERS - 1)) ? '0 : sel + 1'b1;
        if (push) begin
            lock_d = 1'b0;
        end else if (s_req_o) begin
            lock_d     = 1'b1;
            lock_idx_d = sel;
        end else if (lock_q) begin
            // Locked master withdrew its request before being granted.
            lock_d = 1'b0;
            err_d  = 1'b1;
        end
        if (s_rvalid_i && cnt_q == '0) err_d = 1'b1;
        if (push && !pop) cnt_d = cnt_q + 1'b1;
        else if (pop && !push) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q       <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) fifo_q[i] <= '0;
        end else begin
            rr_q       <= rr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
            if (push) begin
                fifo_q[wr_q] <= sel;
                wr_q         <= ptr_inc(wr_q);
            end
            if (pop) rd_q <= ptr_inc(rd_q);
        end
    end

endmodule

// File: tb/tb_ibex_bus_arbiter.sv
// Directed bench for ibex_bus_arbiter; grant order feeds a scoreboard queue that the
// response checks drain. A second fixed-priority instance shares the stimulus.
module tb_ibex_bus_arbiter;
    localparam int N  = 2;
    localparam int MO = 2;
    localparam int CW = $clog2(MO + 1);

    logic clk = 1'b0;
    logic rst_ni;
    always #5 clk = ~clk;

    logic [N-1:0]    m_req_i, m_we_i;
    logic [N*4-1:0]  m_be_i;
    logic [N*32-1:0] m_addr_i, m_wdata_i;
    logic            s_gnt_i, s_rvalid_i, s_err_i;
    logic [31:0]     s_rdata_i;

    logic [N-1:0]  m_gnt_o, m_rvalid_o;
    logic [31:0]   m_rdata_o, s_addr_o, s_wdata_o;
    logic          m_err_o, s_req_o, s_we_o, protocol_err_o;
    logic [3:0]    s_be_o;
    logic [CW-1:0] outstanding_o;

    logic [N-1:0]  fp_gnt, fp_rvalid;
    logic [31:0]   fp_rdata, fp_addr, fp_wdata;
    logic          fp_err, fp_req, fp_we, fp_perr;
    logic [3:0]    fp_be;
    logic [CW-1:0] fp_out;

    ibex_bus_arbiter #(.NUM_MASTERS(N), .MAX_OUTSTANDING(MO), .RR_EN(1'b1)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .m_req_i(m_req_i), .m_gnt_o(m_gnt_o),
        .m_rvalid_o(m_rvalid_o), .m_we_i(m_we_i), .m_be_i(m_be_i), .m_addr_i(m_addr_i),
        .m_wdata_i(m_wdata_i), .m_rdata_o(m_rdata_o), .m_err_o(m_err_o), .s_req_o(s_req_o),
        .s_we_o(s_we_o), .s_be_o(s_be_o), .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o),
        .s_gnt_i(s_gnt_i), .s_rvalid_i(s_rvalid_i), .s_err_i(s_err_i), .s_rdata_i(s_rdata_i),
        .outstanding_o(outstanding_o), .protocol_err_o(protocol_err_o)
    );

    ibex_bus_arbiter #(.NUM_MASTERS(N), .MAX_OUTSTANDING(MO), .RR_EN(1'b0)) dut_fp (
        .clk_i(clk), .rst_ni(rst_ni), .m_req_i(m_req_i), .m_gnt_o(fp_gnt),
        .m_rvalid_o(fp_rvalid), .m_we_i(m_we_i), .m_be_i(m_be_i), .m_addr_i(m_addr_i),
        .m_wdata_i(m_wdata_i), .m_rdata_o(fp_rdata), .m_err_o(fp_err), .s_req_o(fp_req),
        .s_we_o(fp_we), .s_be_o(fp_be), .s_addr_o(fp_addr), .s_wdata_o(fp_wdata),
        .s_gnt_i(s_gnt_i), .s_rvalid_i(s_rvalid_i), .s_err_i(s_err_i), .s_rdata_i(s_rdata_i),
        .outstanding_o(fp_out), .protocol_err_o(fp_perr)
    );

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] req, input logic gnt, input logic rv,
                         input logic [31:0] rd);
        @(negedge clk);
        m_req_i    = req;
        s_gnt_i    = gnt;
        s_rvalid_i = rv;
        s_rdata_i  = rd;
        #1;
    endtask

    // id < 0 means no grant is expected this cycle.
    task automatic expect_gnt(input string tag, input int id);
        if (id < 0) begin
            chk(tag, 64'(m_gnt_o), 64'd0);
        end else begin
            chk(tag, 64'(m_gnt_o), 64'd1 << id);
            exp_q.push_back(id);
        end
    endtask

    task automatic expect_rsp(input string tag, input logic [31:0] rd);
        logic [63:0] e;
        e = '0;
        if (exp_q.size() > 0) e = 64'd1 << exp_q.pop_front();
        chk({tag, "_rvalid"}, 64'(m_rvalid_o), e);
        chk({tag, "_rdata"}, 64'(m_rdata_o), 64'(rd));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_ni = 1'b0;
        m_req_i = '0; s_gnt_i = 1'b0; s_rvalid_i = 1'b0; s_rdata_i = '0;
        #1;
        chk("rst_s_req", 64'(s_req_o), 64'd0);
        chk("rst_outstanding", 64'(outstanding_o), 64'd0);
        chk("rst_perr", 64'(protocol_err_o), 64'd0);
        chk("rst_gnt", 64'(m_gnt_o), 64'd0);
        exp_q.delete();
        @(negedge clk);
        rst_ni = 1'b1;
    endtask

    initial begin
        rst_ni = 1'b0;
        m_req_i = '0; m_we_i = 2'b10; m_be_i = {4'h3, 4'hF};
        m_addr_i = {32'h0, 32'h100}; m_wdata_i = {32'hAAAA5555, 32'h0};
        s_gnt_i = 1'b0; s_rvalid_i = 1'b0; s_err_i = 1'b0; s_rdata_i = '0;
        do_reset();

        // Single read from m0
        drive(2'b01, 1'b1, 1'b0, 32'h0);
        chk("t1_addr", 64'(s_addr_o), 64'h100);
        chk("t1_be", 64'(s_be_o), 64'hF);
        expect_gnt("t1_gnt", 0);
        drive(2'b00, 1'b0, 1'b0, 32'h0);
        chk("t1_outstanding", 64'(outstanding_o), 64'd1);
        drive(2'b00, 1'b0, 1'b1, 32'hDEADBEEF);
        expect_rsp("t1_rsp", 32'hDEADBEEF);
        drive(2'b00, 1'b0, 1'b0, 32'h0);
        chk("t1_drained", 64'(outstanding_o), 64'd0);

        // Both masters request continuously; RR alternates, fixed priority sticks to m0
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(2'b11, 1'b1, k > 0, 32'h20 + k);
            expect_gnt($sformatf("t2_rr_gnt%0d", k), k % 2);
            chk($sformatf("t2_fp_gnt%0d", k), 64'(fp_gnt), 64'd1);
            if (k > 0) expect_rsp($sformatf("t2_rsp%0d", k), 32'h20 + k);
        end
        drive(2'b00, 1'b0, 1'b1, 32'h24);
        expect_rsp("t2_rsp4", 32'h24);
        drive(2'b00, 1'b0, 1'b0, 32'h0);
        chk("t2_drained", 64'(outstanding_o), 64'd0);

        // Lock holds m0 while grant is withheld; then in-order responses
        do_reset();
        m_addr_i = {32'h444, 32'h300};
        drive(2'b01, 1'b0, 1'b0, 32'h0);
        chk("t3_addr0", 64'(s_addr_o), 64'h300);
        expect_gnt("t3_gnt0", -1);
        for (int k = 1; k < 3; k++) begin
            drive(2'b11, 1'b0, 1'b0, 32'h0);
            chk($sformatf("t3_addr%0d", k), 64'(s_addr_o), 64'h300);
            expect_gnt($sformatf("t3_gnt%0d", k), -1);
        end
        drive(2'b11, 1'b1, 1'b0, 32'h0);
        chk("t3_addr3", 64'(s_addr_o), 64'h300);
        expect_gnt("t3_gnt3", 0);
        drive(2'b11, 1'b1, 1'b0, 32'h0);
        chk("t3_addr4", 64'(s_addr_o), 64'h444);
        chk("t3_we4", 64'(s_we_o), 64'd1);
        chk("t3_be4", 64'(s_be_o), 64'h3);
        expect_gnt("t3_gnt4", 1);
        drive(2'b00, 1'b0, 1'b1, 32'h1);
        expect_rsp("t4_rsp0", 32'h1);
        drive(2'b00, 1'b0, 1'b1, 32'h2);
        expect_rsp("t4_rsp1", 32'h2);
        drive(2'b00, 1'b0, 1'b0, 32'h0);
        chk("t4_drained", 64'(outstanding_o), 64'd0);

        // Full blocks requests with no bypass; push and pop together keep the count
        do_reset();
        drive(2'b11, 1'b1, 1'b0, 32'h0);
        expect_gnt("t5_gnt0", 0);
        drive(2'b11, 1'b1, 1'b0, 32'h0);
        expect_gnt("t5_gnt1", 1);
        drive(2'b11, 1'b1, 1'b0, 32'h0);
        chk("t5_full_cnt", 64'(outstanding_o), 64'd2);
        chk("t5_full_req", 64'(s_req_o), 64'd0);
        chk("t5_full_addr", 64'(s_addr_o), 64'd0);
        expect_gnt("t5_full_gnt", -1);
        drive(2'b11, 1'b1, 1'b1, 32'h5);
        chk("t5_nobypass_req", 64'(s_req_o), 64'd0);
        expect_gnt("t5_nobypass_gnt", -1);
        expect_rsp("t5_rsp0", 32'h5);
        drive(2'b11, 1'b1, 1'b1, 32'h6);
        chk("t5_cnt1", 64'(outstanding_o), 64'd1);
        chk("t5_req_again", 64'(s_req_o), 64'd1);
        expect_gnt("t5_gnt2", 0);
        expect_rsp("t5_rsp1", 32'h6);
        drive(2'b00, 1'b0, 1'b0, 32'h0);
        chk("t5_cnt_same", 64'(outstanding_o), 64'd1);
        drive(2'b00, 1'b0, 1'b1, 32'h7);
        expect_rsp("t5_rsp2", 32'h7);
        drive(2'b00, 1'b0, 1'b0, 32'h0);
        chk("t5_drained", 64'(outstanding_o), 64'd0);
        chk("t5_no_perr", 64'(protocol_err_o), 64'd0);

        // Response with nothing outstanding sets a sticky error
        do_reset();
        drive(2'b00, 1'b0, 1'b1, 32'hBAD);
        expect_rsp("t6_rsp", 32'hBAD);
        drive(2'b00, 1'b0, 1'b0, 32'h0);
        chk("t6_perr", 64'(protocol_err_o), 64'd1);
        drive(2'b00, 1'b0, 1'b0, 32'h0);
        chk("t6_perr_held", 64'(protocol_err_o), 64'd1);
        do_reset();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
